// File: rtl/idex_pipe_pkg.sv
// Shared definitions for the ID->EX pipeline stage: default field widths,
// the decoded micro-op layout and the skid-buffer state encoding.
package idex_pipe_pkg;

    localparam int UNIT_W_DEF = 3;
    localparam int OP_W_DEF   = 6;
    localparam int DATA_W_DEF = 32;
    localparam int TAG_W_DEF  = 4;
    localparam int ADDR_W_DEF = 32;

    typedef logic [UNIT_W_DEF-1:0] ex_unit_t;
    typedef logic [OP_W_DEF-1:0]   op_t;
    typedef logic [DATA_W_DEF-1:0] data_t;
    typedef logic [TAG_W_DEF-1:0]  tag_t;
    typedef logic [ADDR_W_DEF-1:0] addr_t;

    // Field order MSB->LSB matches the flat per-lane payload on the ports
    typedef struct packed {
        ex_unit_t unit;
        op_t      op;
        data_t    val;
        tag_t     tag;
        addr_t    target;
        addr_t    pc_addr;
    } ex_uop_t;

    localparam int PLD_W_DEF = $bits(ex_uop_t);

    // Occupancy of the two-entry skid buffer
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } idex_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, holding at all-ones once reached
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/idex_pipe.sv
// Elastic ID->EX stage: two-entry skid buffer (main drives the outputs,
// skid absorbs the one bundle accepted while EX stalls), synchronous flush
// and a saturating back-pressure counter.
module idex_pipe
    import idex_pipe_pkg::*;
#(
    parameter  int LANES  = 2,
    parameter  int UNIT_W = 3,
    parameter  int OP_W   = 6,
    parameter  int DATA_W = 32,
    parameter  int TAG_W  = 4,
    parameter  int ADDR_W = 32,
    parameter  int CNT_W  = 16,
    localparam int PLD_W  = UNIT_W + OP_W + DATA_W + TAG_W + 2 * ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES-1:0]       in_lane_valid,
    input  logic [LANES*PLD_W-1:0] in_payload,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES-1:0]       out_lane_valid,
    output logic [LANES*PLD_W-1:0] out_payload,
    output logic [CNT_W-1:0]       stall_cnt
);

    idex_state_t            state;
    logic [LANES-1:0]       main_lv;
    logic [LANES*PLD_W-1:0] main_pld;
    logic [LANES-1:0]       skid_lv;
    logic [LANES*PLD_W-1:0] skid_pld;

    logic in_fire;
    logic out_fire;
    logic accept;

    // Handshake flags come straight off the state flops, so neither
    // in_valid nor out_ready has a combinational path to them
    assign in_ready  = (state != ST_TWO);
    assign out_valid = (state != ST_EMPTY);

    assign out_lane_valid = main_lv;
    assign out_payload    = main_pld;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    // A bundle with no occupied lanes is consumed but never stored
    assign accept   = in_fire & (|in_lane_valid);

    // Skid-buffer state machine and entry storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_EMPTY;
            main_lv  <= '0;
            main_pld <= '0;
            skid_lv  <= '0;
            skid_pld <= '0;
        end else if (flush) begin
            state   <= ST_EMPTY;
            main_lv <= '0;
            skid_lv <= '0;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_lv  <= in_lane_valid;
                        main_pld <= in_payload;
                        state    <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && out_fire) begin
                        main_lv  <= in_lane_valid;
                        main_pld <= in_payload;
                    end else if (accept) begin
                        skid_lv  <= in_lane_valid;
                        skid_pld <= in_payload;
                        state    <= ST_TWO;
                    end else if (out_fire) begin
                        main_lv <= '0;
                        state   <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only the drain can happen
                    if (out_fire) begin
                        main_lv  <= skid_lv;
                        main_pld <= skid_pld;
                        skid_lv  <= '0;
                        state    <= ST_ONE;
                    end
                end
                default: begin
                    main_lv <= '0;
                    skid_lv <= '0;
                    state   <= ST_EMPTY;
                end
            endcase
        end
    end

    // Back-pressure cycles, counted even while flush is asserted
    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (out_valid & ~out_ready),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_idex_pipe.sv
// Directed testbench for idex_pipe (CNT_W=4 so saturation is reachable).
module tb_idex_pipe;

    localparam int LANES = 2;
    localparam int PLD_W = 109;
    localparam int CNT_W = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES-1:0]       in_lane_valid;
    logic [LANES*PLD_W-1:0] in_payload;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES-1:0]       out_lane_valid;
    logic [LANES*PLD_W-1:0] out_payload;
    logic [CNT_W-1:0]       stall_cnt;

    int passed = 0;
    int total  = 0;

    idex_pipe #(
        .LANES (LANES),
        .UNIT_W(3),
        .OP_W  (6),
        .DATA_W(32),
        .TAG_W (4),
        .ADDR_W(32),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_lane_valid (in_lane_valid),
        .in_payload    (in_payload),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_lane_valid(out_lane_valid),
        .out_payload   (out_payload),
        .stall_cnt     (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bundle whose lane fields are derived from seed; lane0 tag = seed[3:0]
    function automatic logic [LANES*PLD_W-1:0] mk(input int seed);
        logic [LANES*PLD_W-1:0] b;
        logic [PLD_W-1:0]       l;
        for (int i = 0; i < LANES; i++) begin
            l = {3'(i), 6'(seed), 32'(seed * 1000 + i), 4'(seed),
                 32'(32'h1000 + seed), 32'(32'h2000 + seed)};
            b[i*PLD_W +: PLD_W] = l;
        end
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [LANES-1:0] lv, input int seed);
        in_valid      = v;
        in_lane_valid = lv;
        in_payload    = mk(seed);
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 2'b00, 0);
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
        total++; if (out_lane_valid !== 2'b00) $display("FAIL reset_lane_valid: got %b want 00", out_lane_valid); else passed++;
        total++; if (out_payload !== '0) $display("FAIL reset_payload: got %h want 0", out_payload); else passed++;
        total++; if (stall_cnt !== 4'd0) $display("FAIL reset_stall: got %0d want 0", stall_cnt); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 2'b11, k);
            step();
            total++;
            if (out_valid !== 1'b1 || out_payload !== mk(k) || in_ready !== 1'b1)
                $display("FAIL b2b_%0d: valid=%b rdy=%b tag=%0d want valid=1 rdy=1 tag=%0d",
                         k, out_valid, in_ready, out_payload[64 +: 4], k);
            else passed++;
        end
        drive(1'b0, 2'b00, 0);
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", out_valid); else passed++;
        total++; if (stall_cnt !== 4'd0) $display("FAIL b2b_stall: got %0d want 0", stall_cnt); else passed++;
    endtask

    task automatic test_stall_order();
        do_reset();
        drive(1'b1, 2'b11, 10);  // A
        step();
        total++; if (out_payload !== mk(10) || in_ready !== 1'b1) $display("FAIL stall_a: rdy=%b tag=%0d want rdy=1 tag=10", in_ready, out_payload[64 +: 4]); else passed++;
        drive(1'b1, 2'b11, 11);  // B
        step();
        total++; if (in_ready !== 1'b0) $display("FAIL stall_full: in_ready got %b want 0", in_ready); else passed++;
        drive(1'b1, 2'b11, 12);  // C, held at the input
        step();
        step();
        total++; if (out_payload !== mk(10) || out_valid !== 1'b1) $display("FAIL stall_hold: tag=%0d want 10", out_payload[64 +: 4]); else passed++;
        total++; if (stall_cnt !== 4'd3) $display("FAIL stall_cnt: got %0d want 3", stall_cnt); else passed++;
        out_ready = 1'b1;
        step();
        total++; if (out_payload !== mk(11) || in_ready !== 1'b1) $display("FAIL order_b: rdy=%b tag=%0d want rdy=1 tag=11", in_ready, out_payload[64 +: 4]); else passed++;
        step();
        total++; if (out_payload !== mk(12) || out_valid !== 1'b1) $display("FAIL order_c: valid=%b tag=%0d want valid=1 tag=12", out_valid, out_payload[64 +: 4]); else passed++;
        drive(1'b0, 2'b00, 0);
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL order_drain: got %b want 0", out_valid); else passed++;
        total++; if (stall_cnt !== 4'd3) $display("FAIL order_stall: got %0d want 3", stall_cnt); else passed++;
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 2'b11, 3);
        step();
        drive(1'b1, 2'b11, 4);
        step();
        flush = 1'b1;
        drive(1'b1, 2'b11, 5);
        step();
        flush = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL flush_state: valid=%b rdy=%b want valid=0 rdy=1", out_valid, in_ready); else passed++;
        total++; if (out_lane_valid !== 2'b00) $display("FAIL flush_lv: got %b want 00", out_lane_valid); else passed++;
        total++; if (stall_cnt !== 4'd2) $display("FAIL flush_stall: got %0d want 2", stall_cnt); else passed++;
        drive(1'b0, 2'b00, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (out_valid !== 1'b0) $display("FAIL flush_quiet_%0d: valid got %b want 0", k, out_valid); else passed++;
        end
    endtask

    task automatic test_null_bundle();
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 2'b00, 6);
        step();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL null_skip: valid=%b rdy=%b want valid=0 rdy=1", out_valid, in_ready); else passed++;
        drive(1'b1, 2'b10, 7);
        step();
        total++; if (out_valid !== 1'b1 || out_lane_valid !== 2'b10) $display("FAIL null_next: valid=%b lv=%b want valid=1 lv=10", out_valid, out_lane_valid); else passed++;
        total++; if (out_payload[PLD_W +: PLD_W] !== mk(7) >> PLD_W) $display("FAIL null_lane1: got %h want %h", out_payload[PLD_W +: PLD_W], mk(7) >> PLD_W); else passed++;
        drive(1'b0, 2'b00, 0);
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL null_drain: got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_saturation();
        do_reset();
        drive(1'b1, 2'b01, 9);
        step();
        drive(1'b0, 2'b00, 0);
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 14 || k == 15 || k == 20) begin
                total++;
                if (stall_cnt !== ((k < 15) ? 4'(k) : 4'd15))
                    $display("FAIL sat_%0d: got %0d want %0d", k, stall_cnt, (k < 15) ? k : 15);
                else passed++;
            end
        end
        total++; if (out_payload !== mk(9) || out_lane_valid !== 2'b01) $display("FAIL sat_stable: lv=%b tag=%0d want lv=01 tag=9", out_lane_valid, out_payload[64 +: 4]); else passed++;
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 2'b11, 1);
        step();
        drive(1'b1, 2'b11, 2);
        step();
        drive(1'b0, 2'b00, 0);
        #2;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || out_lane_valid !== 2'b00) $display("FAIL arst_out: valid=%b lv=%b want 0/00", out_valid, out_lane_valid); else passed++;
        total++; if (stall_cnt !== 4'd0 || out_payload !== '0) $display("FAIL arst_cnt: cnt=%0d want 0 (payload zero)", stall_cnt); else passed++;
        #1;
        rst = 1'b0;
        step();
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL arst_release: rdy=%b valid=%b want 1/0", in_ready, out_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall_order();
        test_flush();
        test_null_bundle();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
